// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the
// downstream display logic that consumes its packed digits.
package bin2bcd_seq_pkg;

    // Converter FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bits per BCD digit.
    localparam int BCD_DIGIT_W = 4;

    // A digit at or above this value would overflow past 9 after the next
    // doubling, so it is pre-corrected by +3 before the shift.
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESHOLD = 4'd5;

    // Digit positions inside the packed BCD word (for the display mux).
    localparam int UNI = 0;
    localparam int DEC = 1;
    localparam int CEN = 2;

    // Double-dabble correction step for one digit; the 4-bit sum drops any
    // carry on purpose (inputs >= 13 never occur in a legal conversion).
    function automatic logic [BCD_DIGIT_W-1:0] add3_digit(input logic [BCD_DIGIT_W-1:0] d);
        logic [BCD_DIGIT_W-1:0] r;
        if (d >= ADD3_THRESHOLD) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // True when DIGITS decimal digits can represent every WIDTH-bit value.
    function automatic bit bcd_capacity_ok(input int digits, input int width);
        longint p10;
        longint maxv;
        p10 = 64'sd1;
        for (int i = 0; i < digits; i++) begin
            p10 = p10 * 64'sd10;
        end
        maxv = (64'sd1 <<< width) - 64'sd1;
        return (p10 > maxv);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit shift-add-3 correction: adds 3 when the digit is 5 or more.
module bcd_add3_digit
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Conditional +3 correction ahead of the next left shift.
    always_comb begin
        digit_o = add3_digit(digit_i);
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (double dabble). One start request
// runs WIDTH shift steps; the finished result is loaded into bcd_out in the
// same cycle that done pulses, so downstream logic never sees partial digits.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH-1:0]                bin_in,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Refuse to build a converter whose digit count cannot hold the input range.
    if (!bcd_capacity_ok(DIGITS, WIDTH)) begin : g_param_err
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q,   bin_d;
    logic [BCD_W-1:0]   scr_q,   scr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic               done_q,  done_d;
    logic               busy_q,  busy_d;

    logic [BCD_W-1:0]   scr_adj_s;
    logic [BCD_W-1:0]   scr_shift_s;
    logic [WIDTH-1:0]   bin_shift_s;

    // One correction cell per scratch digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (scr_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Shift the corrected scratch and the binary register left as one word;
    // the binary MSB moves into scratch bit 0.
    always_comb begin
        scr_shift_s = {scr_adj_s[BCD_W-2:0], bin_q[WIDTH-1]};
        bin_shift_s = {bin_q[WIDTH-2:0], 1'b0};
    end

    // Next-state logic: start acceptance, shift steps and result hand-off.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    scr_d   = {BCD_W{1'b0}};
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            SHIFT: begin
                scr_d = scr_shift_s;
                bin_d = bin_shift_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_shift_s;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= {WIDTH{1'b0}};
            scr_q   <= {BCD_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            bcd_q   <= {BCD_W{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        busy    = busy_q;
        done    = done_q;
        bcd_out = bcd_q;
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus a randomly ordered
// full sweep, compared against an arithmetic decimal-digit reference.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int LAT    = WIDTH;

    logic                  clk;
    logic                  rst;
    logic [WIDTH-1:0]      bin_in;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;

    int checks   = 0;
    int failures = 0;
    int busy_cnt;
    int partial_err;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Counts a comparison and reports it if the observed value is wrong.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, units in the low nibble.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Number of nibbles above 9 in a packed BCD word.
    function automatic int bad_digits(input logic [4*DIGITS-1:0] w);
        int n;
        n = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] > 4'd9) n++;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input int v);
        bin_in = WIDTH'(v);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Wait (bounded) for done; bin_in is scrambled meanwhile and must not matter.
    task automatic wait_done(output int lat);
        logic [4*DIGITS-1:0] prev;
        prev = bcd_out;
        lat = 0;
        busy_cnt = 0;
        partial_err = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (bcd_out !== prev) partial_err++;
            bin_in = WIDTH'($urandom);
            tick();
            lat++;
        end
    endtask

    task automatic do_conv(input int v, input string tag);
        int lat;
        start_conv(v);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(LAT));
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(ref_bcd(v)));
        chk({tag, "_digits_le9"}, 32'(bad_digits(bcd_out)), 32'd0);
        chk({tag, "_no_partial"}, 32'(partial_err), 32'd0);
        tick();
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        int order[256];

        rst    = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'h000);
        rst = 1'b1;
        tick();

        // Zero input: full-length run, busy for exactly WIDTH cycles.
        start_conv(0);
        wait_done(lat);
        chk("zero_busy_cycles", 32'(busy_cnt), 32'(LAT));
        chk("zero_latency", 32'(lat), 32'(LAT));
        chk("zero_bcd", 32'(bcd_out), 32'h000);
        chk("zero_busy_at_done", 32'(busy), 32'd0);
        tick();
        chk("zero_done_1cyc", 32'(done), 32'd0);

        do_conv(255, "max");
        chk("max_bcd_const", 32'(bcd_out), 32'h255);
        do_conv(128, "v128");
        chk("v128_bcd_const", 32'(bcd_out), 32'h128);
        do_conv(99, "v99");
        chk("v99_bcd_const", 32'(bcd_out), 32'h099);

        // start while busy is ignored and not queued.
        bin_in = 8'd37;
        start  = 1'b1;
        tick();
        bin_in = 8'd200;
        for (int i = 0; i < 6; i++) tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 28; i++) begin
            if (done) begin
                ndone++;
                chk("collide_bcd", 32'(bcd_out), 32'h037);
            end
            tick();
        end
        chk("collide_done_count", 32'(ndone), 32'd1);

        // Back-to-back: restart in the done cycle.
        start_conv(5);
        wait_done(lat);
        chk("b2b_first_bcd", 32'(bcd_out), 32'h005);
        bin_in = 8'd10;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done(lat);
        chk("b2b_gap", 32'(lat + 1), 32'(LAT + 1));
        chk("b2b_bcd", 32'(bcd_out), 32'h010);
        tick();

        // Reset mid-conversion aborts with no done pulse.
        start_conv(123);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", 32'(bcd_out), 32'h000);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        chk("abort_quiet", 32'(ndone), 32'd0);
        do_conv(123, "after_abort");
        chk("after_abort_const", 32'(bcd_out), 32'h123);

        // Full sweep in shuffled order with random idle gaps.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            int gap;
            do_conv(order[i], $sformatf("sweep%0d", order[i]));
            gap = int'($urandom_range(2, 0));
            for (int k = 0; k < gap; k++) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
